// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo write-side round-robin arbiter:
// FSM state encoding and helpers that derive the pointer/counter widths.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Width of an index into NUM_REQ requesters (prio_ptr, owner, grant_id).
    function automatic int idx_width(input int num_req);
        if (num_req > 32'sd1) begin
            return $clog2(num_req);
        end else begin
            return 32'sd1;
        end
    endfunction

    // Width of the burst counter, which must be able to hold MAX_BURST itself.
    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst + 32'sd1);
    endfunction

    localparam int DEF_NUM_REQ   = 32'sd4;
    localparam int DEF_MAX_BURST = 32'sd2;
    localparam int DEF_PTR_W     = idx_width(DEF_NUM_REQ);
    localparam int DEF_GRANT_W   = idx_width(DEF_NUM_REQ);
    localparam int DEF_BURST_W   = burst_width(DEF_MAX_BURST);

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set bit of 'valid' found when
// scanning start, start+1, ... wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     start,
    output logic [IDW-1:0]     idx,
    output logic               found
);

    logic [IDW:0] cand_s;

    // Scan from the farthest offset down to offset 0 so the closest hit wins.
    always_comb begin
        idx    = {IDW{1'b0}};
        found  = 1'b0;
        cand_s = {(IDW+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = {1'b0, start} + (IDW+1)'(k);
            cand_s = (cand_s >= (IDW+1)'(NUM_REQ)) ? (cand_s - (IDW+1)'(NUM_REQ)) : cand_s;
            idx    = valid[cand_s[IDW-1:0]] ? cand_s[IDW-1:0] : idx;
            found  = valid[cand_s[IDW-1:0]] | found;
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers.
// A winner may keep the grant for up to MAX_BURST words; accepted words pass
// straight through to the fifo in the cycle they are accepted.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATAW     = 8,
    parameter int MAX_BURST = 2,
    parameter int CNTW      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATAW-1:0]      req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w,
    output logic [DATAW-1:0]              fifo_data_in,
    input  logic                          fifo_full,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          grant_valid,
    output logic                          busy,
    output logic [CNTW-1:0]               xfer_count
);

    localparam int IDW = idx_width(NUM_REQ);
    localparam int BCW = burst_width(MAX_BURST);

    arb_state_t      state_r,     state_next_s;
    logic [IDW-1:0]  prio_ptr_r,  prio_next_s;
    logic [IDW-1:0]  owner_r,     owner_next_s;
    logic [BCW-1:0]  burst_cnt_r, burst_next_s;
    logic [BCW-1:0]  burst_inc_s;
    logic [CNTW-1:0] xfer_count_r, xfer_next_s;

    logic [IDW-1:0]  pick_idx_s;
    logic            pick_found_s;
    logic [IDW-1:0]  grant_id_s;
    logic            grant_valid_s;
    logic            fire_s;

    // Next pointer value with wrap at the last requester.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
        if (p == IDW'(NUM_REQ - 32'sd1)) begin
            return {IDW{1'b0}};
        end else begin
            return p + IDW'(1'b1);
        end
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .valid (req_valid),
        .start (prio_ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Grant selection: owner keeps the port in OWN, otherwise rotate-scan; nothing while in reset.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        if (!rst) begin
            grant_valid_s = 1'b0;
        end else if (state_r == OWN) begin
            grant_valid_s = req_valid[owner_r];
            grant_id_s    = owner_r;
        end else begin
            grant_valid_s = pick_found_s;
            grant_id_s    = pick_idx_s;
        end
    end

    assign fire_s = grant_valid_s & ~fifo_full;

    // Handshake and fifo-side outputs driven directly from the current grant.
    always_comb begin
        req_ready    = {NUM_REQ{1'b0}};
        fifo_data_in = {DATAW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = fire_s & (grant_id_s == IDW'(i));
        end
        if (grant_valid_s) begin
            fifo_data_in = req_data[grant_id_s*DATAW +: DATAW];
        end else begin
            fifo_data_in = {DATAW{1'b0}};
        end
    end

    // Next-state logic for the FSM, priority pointer, owner and burst counter.
    always_comb begin
        state_next_s = state_r;
        prio_next_s  = prio_ptr_r;
        owner_next_s = owner_r;
        burst_next_s = burst_cnt_r;
        burst_inc_s  = burst_cnt_r + BCW'(1'b1);
        xfer_next_s  = fire_s ? (xfer_count_r + CNTW'(1'b1)) : xfer_count_r;
        case (state_r)
            IDLE: begin
                if (fire_s) begin
                    if (MAX_BURST == 32'sd1) begin
                        prio_next_s = wrap_inc(grant_id_s);
                    end else begin
                        state_next_s = OWN;
                        owner_next_s = grant_id_s;
                        burst_next_s = BCW'(1'b1);
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN: begin
                if (!req_valid[owner_r]) begin
                    // Owner went away: release, costing one cycle without a write.
                    state_next_s = IDLE;
                    prio_next_s  = wrap_inc(owner_r);
                    burst_next_s = {BCW{1'b0}};
                end else if (fire_s) begin
                    if (burst_inc_s == BCW'(MAX_BURST)) begin
                        state_next_s = IDLE;
                        prio_next_s  = wrap_inc(owner_r);
                        burst_next_s = {BCW{1'b0}};
                    end else begin
                        burst_next_s = burst_inc_s;
                    end
                end else begin
                    state_next_s = OWN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            prio_ptr_r   <= {IDW{1'b0}};
            owner_r      <= {IDW{1'b0}};
            burst_cnt_r  <= {BCW{1'b0}};
            xfer_count_r <= {CNTW{1'b0}};
        end else begin
            state_r      <= state_next_s;
            prio_ptr_r   <= prio_next_s;
            owner_r      <= owner_next_s;
            burst_cnt_r  <= burst_next_s;
            xfer_count_r <= xfer_next_s;
        end
    end

    assign fifo_w      = fire_s;
    assign grant_id    = grant_id_s;
    assign grant_valid = grant_valid_s;
    assign busy        = (state_r == OWN);
    assign xfer_count  = xfer_count_r;

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin write-side arbiter that shares one fifo write port (w/data_in/full) between NUM_REQ independent producers. Each producer uses a valid/ready handshake. A requester may hold the grant for up to MAX_BURST consecutive words, so short packets stay contiguous in the fifo. Sits directly in front of the existing fifo instance in the adder datapath.

Parameters:
NUM_REQ, 4, number of requesters (>=2; need not be a power of 2)
DATAW, 8, data width; must match the fifo DATAW
MAX_BURST, 2, max consecutive accepted words per grant (>=1)
CNTW, 16, width of the transfer counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset; state clears on a rising clk edge while rst==0
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATAW  requester i occupies bits [i*DATAW +: DATAW]
req_ready  out  NUM_REQ  one-hot or zero; word i accepted when req_valid[i] && req_ready[i]
fifo_w  out  1  to fifo w
fifo_data_in  out  DATAW  to fifo data_in
fifo_full  in  1  from fifo full
grant_id  out  clog2(NUM_REQ)  index currently granted (valid when grant_valid)
grant_valid  out  1  a requester is granted this cycle
busy  out  1  FSM in OWN
xfer_count  out  CNTW  total accepted words, wraps modulo 2^CNTW

Behaviour:
- State: fsm {IDLE, OWN}; prio_ptr; owner; burst_cnt (clog2(MAX_BURST+1) bits); xfer_count.
- Reset (rst==0 at posedge): fsm=IDLE, prio_ptr=0, owner=0, burst_cnt=0, xfer_count=0. While rst==0, req_ready=0 and fifo_w=0 combinationally. grant_valid=0, grant_id=0, busy=0 after reset.
- Grant (combinational):
  - IDLE: first i with req_valid[i]=1, scanning prio_ptr, prio_ptr+1, ... with wrap at NUM_REQ-1 to 0. None valid -> grant_valid=0.
  - OWN: grant=owner if req_valid[owner]; else grant_valid=0.
- fire = grant_valid && !fifo_full.
- Outputs: fifo_w=fire; fifo_data_in = req_data of grant_id when grant_valid, else 0; req_ready[grant_id]=!fifo_full, all other bits 0.
- Zero-latency path: the accepted word reaches fifo_w/fifo_data_in in the same cycle it is accepted.
- fifo_full=1: no transfer, no state change (burst_cnt, prio_ptr, owner held). A full fifo never receives a write.
- Transitions (posedge, rst==1):
  - IDLE & fire & MAX_BURST==1: stay IDLE; prio_ptr = grant+1 (wrap).
  - IDLE & fire & MAX_BURST>1: go to OWN; owner=grant; burst_cnt=1.
  - OWN & fire: burst_cnt+1. If the new value equals MAX_BURST, go to IDLE with prio_ptr=owner+1 (wrap) and burst_cnt=0.
  - OWN & !req_valid[owner]: go to IDLE; prio_ptr=owner+1 (wrap); burst_cnt=0. This costs one bubble cycle with no write.
  - OWN & req_valid[owner] & fifo_full: hold.
- xfer_count increments by 1 on every fire and wraps silently.
- Reset mid-burst: the burst is abandoned and no write occurs in the reset cycle. Arbitration restarts from requester 0.
- req_data may change only after acceptance; the arbiter does not register data.

Decomposition:
- Shared package/header fifo_arb_pkg: fsm state encodings (IDLE=0, OWN=1) and the clog2-derived width constants for ptr, burst_cnt and grant_id.
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs are valid vector and start ptr; outputs are index and found. It is instantiated once for the IDLE grant.
- Top holds the FSM, counters and output muxing.

Test Plan:
All scenarios use NUM_REQ=4, DATAW=8, MAX_BURST=2, driving the existing fifo (depth 8).
1. Reset: rst=0 for 2 cycles with req_valid=4'b1111 -> fifo_w=0, req_ready=0, xfer_count=0, busy=0. First cycle after rst=1 grants requester 0.
2. Single requester: only req 1 valid with 0x11, 0x12, 0x13 -> written on 3 consecutive cycles in order. busy=1 after 0x11, IDLE after 0x12, re-granted (wrap from ptr 2) for 0x13. xfer_count=3.
3. Fairness: all four valid continuously, data = 0xA0+id -> fifo receives A0,A0,A1,A1,A2,A2,A3,A3, fills, full=1, then fifo_w=0 and req_ready=0. After 3 fifo reads, writes resume with A0,A0,A1.
4. Full mid-burst: req 2 granted, 1 word written, force fifo_full=1 for 3 cycles -> no write, burst_cnt=1 held. On full=0, exactly 1 more word from req 2, then grant moves to req 3.
5. Owner drops: req 0 writes 1 word, deasserts valid while reqs 0 and 3 are valid -> 1 bubble cycle (fifo_w=0), then req 3 granted before req 0.
6. Reset mid-burst: rst=0 for 1 cycle while OWN with owner=2 -> no write that cycle. Next cycle busy=0, req 0 (valid) granted, xfer_count=0.
